// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment time display: active-low segment patterns,
// the adjust-field encodings and the legal field ranges.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] FONT_0 = 7'b1000000;
  localparam logic [6:0] FONT_1 = 7'b1111001;
  localparam logic [6:0] FONT_2 = 7'b0100100;
  localparam logic [6:0] FONT_3 = 7'b0110000;
  localparam logic [6:0] FONT_4 = 7'b0011001;
  localparam logic [6:0] FONT_5 = 7'b0010010;
  localparam logic [6:0] FONT_6 = 7'b0000010;
  localparam logic [6:0] FONT_7 = 7'b1111000;
  localparam logic [6:0] FONT_8 = 7'b0000000;
  localparam logic [6:0] FONT_9 = 7'b0010000;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'b00,
    ADJ_HR   = 2'b01,
    ADJ_MIN  = 2'b10,
    ADJ_RSVD = 2'b11
  } adj_sel_e;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/seg7_font.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes render blank.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = FONT_0;
      4'd1:    seg = FONT_1;
      4'd2:    seg = FONT_2;
      4'd3:    seg = FONT_3;
      4'd4:    seg = FONT_4;
      4'd5:    seg = FONT_5;
      4'd6:    seg = FONT_6;
      4'd7:    seg = FONT_7;
      4'd8:    seg = FONT_8;
      4'd9:    seg = FONT_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_time_display.sv
// HH:MM driver for a 4-digit multiplexed common-anode display: per-frame input snapshot,
// anti-ghosting guard after each digit switch, field blink and "--" for out-of-range fields.
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int GUARD      = 4,
  parameter int LEAD_BLANK = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [1:0] adjust_sel,
  input  logic       colon_on,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W     = $clog2(SCAN_DIV + 1);
  localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
  localparam int GUARD_W   = $clog2(GUARD + 2);

  logic [PRE_W-1:0]   pre;
  logic [1:0]         idx;
  logic [GUARD_W-1:0] guard;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic [4:0]         snap_hr;
  logic [5:0]         snap_min;
  logic               tick;

  assign tick = (pre == PRE_W'(SCAN_DIV - 1));

  // Scan, guard, blink and snapshot state
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre       <= '0;
      idx       <= 2'd0;
      guard     <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      snap_hr   <= '0;
      snap_min  <= '0;
    end else begin
      if (tick) begin
        pre   <= '0;
        idx   <= idx + 2'd1;
        guard <= GUARD_W'(GUARD);
      end else begin
        pre <= pre + 1'b1;
        if (guard != '0) guard <= guard - 1'b1;
      end
      // Capture only at the frame boundary so all four digits come from one sample
      if (tick && idx == 2'd3) begin
        snap_hr  <= hours;
        snap_min <= minutes;
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic       hr_ok, min_ok;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones;

  assign hr_ok    = (snap_hr <= HR_MAX);
  assign min_ok   = (snap_min <= MIN_MAX);
  assign hr_tens  = 4'(snap_hr / 5'd10);
  assign hr_ones  = 4'(snap_hr % 5'd10);
  assign min_tens = 4'(snap_min / 6'd10);
  assign min_ones = 4'(snap_min % 6'd10);

  logic [3:0] digit;
  logic       field_ok;

  always_comb begin
    digit    = min_ones;
    field_ok = min_ok;
    case (idx)
      2'd0: begin digit = min_ones; field_ok = min_ok; end
      2'd1: begin digit = min_tens; field_ok = min_ok; end
      2'd2: begin digit = hr_ones;  field_ok = hr_ok;  end
      2'd3: begin digit = hr_tens;  field_ok = hr_ok;  end
      default: begin digit = min_ones; field_ok = min_ok; end
    endcase
  end

  logic [6:0] font_seg;
  logic [6:0] seg_next;

  seg7_font u_font (
    .digit (digit),
    .seg   (font_seg)
  );

  assign seg_next = field_ok ? font_seg : SEG_DASH;

  adj_sel_e adj;
  logic     hr_field, blink_off, lead_off, digit_off;

  assign adj       = adj_sel_e'(adjust_sel);
  assign hr_field  = idx[1];
  assign blink_off = blink_ph && ((adj == ADJ_HR && hr_field) || (adj == ADJ_MIN && !hr_field));
  assign lead_off  = (LEAD_BLANK != 0) && (idx == 2'd3) && hr_ok && (hr_tens == 4'd0);
  assign digit_off = blink_off || lead_off;

  // Registered pins; the colon follows its digit so it is never lit while that digit is dark
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode <= 4'hF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else if (guard != '0) begin
      anode <= 4'hF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      anode <= digit_off ? 4'hF : ~(4'b0001 << idx);
      seg   <= seg_next;
      dp    <= ~(colon_on && (idx == 2'd2) && !digit_off);
    end
  end

endmodule

// File: tb/tb_seg7_time_display.sv
// Directed bench for seg7_time_display at SCAN_DIV=10, BLINK_DIV=20, GUARD=2, with a
// second instance built with LEAD_BLANK=1 sharing the same inputs.
module tb_seg7_time_display;

  localparam int SCAN_DIV  = 10;
  localparam int BLINK_DIV = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] hours = 5'd0;
  logic [5:0] minutes = 6'd0;
  logic [1:0] adjust_sel = 2'b00;
  logic       colon_on = 1'b0;
  logic [3:0] anode, anode_lb;
  logic [6:0] seg, seg_lb;
  logic       dp, dp_lb;

  int n = 0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  seg7_time_display #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(25), .GUARD(2), .LEAD_BLANK(0)
  ) dut (
    .clk(clk), .reset(reset), .hours(hours), .minutes(minutes),
    .adjust_sel(adjust_sel), .colon_on(colon_on),
    .anode(anode), .seg(seg), .dp(dp)
  );

  seg7_time_display #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(25), .GUARD(2), .LEAD_BLANK(1)
  ) dut_lb (
    .clk(clk), .reset(reset), .hours(hours), .minutes(minutes),
    .adjust_sel(adjust_sel), .colon_on(colon_on),
    .anode(anode_lb), .seg(seg_lb), .dp(dp_lb)
  );

  // n = number of clock edges since reset release; outputs seen after edge n reflect
  // the scan state left by edge n-1.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic bit in_guard(int k);
    return ((k - 1) >= SCAN_DIV) && (((k - 1) % SCAN_DIV) < 2);
  endfunction

  function automatic int pos(int k);
    return ((k - 1) / SCAN_DIV) % 4;
  endfunction

  function automatic bit ph(int k);
    return (((k - 1) / BLINK_DIV) % 2) == 1;
  endfunction

  function automatic logic [3:0] exp_anode(int k, logic [3:0] off_mask);
    logic [3:0] a;
    a = 4'hF;
    if (!in_guard(k) && !off_mask[pos(k)]) a[pos(k)] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    bit found;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({anode, seg, dp} !== {4'hF, 7'h7F, 1'b1})
        $display("FAIL reset_hold cycle=%0d got anode=%b seg=%b dp=%b want 1111 1111111 1", i, anode, seg, dp);
      else passed++;
    end
    reset = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < SCAN_DIV + 2 && !found; i++) begin
      step();
      if (anode !== 4'hF) found = 1;
    end
    total++;
    if (!found) $display("FAIL first_anode no anode low within %0d cycles, anode=%b", SCAN_DIV + 2, anode);
    else passed++;
    total++;
    if ($countones(~anode) != 1) $display("FAIL first_anode_onehot got anode=%b want exactly one low", anode);
    else passed++;
  endtask

  task automatic test_frame();
    logic [6:0] digs [4];
    logic [3:0] e;
    hours = 5'd23;
    minutes = 6'd45;
    digs = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100};
    while (n < 40) step();
    repeat (40) begin
      step();
      e = exp_anode(n, 4'b0000);
      total++;
      if (anode !== e) $display("FAIL frame_anode n=%0d got %b want %b", n, anode, e);
      else passed++;
      if (e != 4'hF) begin
        total++;
        if (seg !== digs[pos(n)]) $display("FAIL frame_seg n=%0d got %b want %b", n, seg, digs[pos(n)]);
        else passed++;
      end
      total++;
      if (dp !== 1'b1) $display("FAIL frame_dp n=%0d got %b want 1", n, dp);
      else passed++;
    end
  endtask

  task automatic test_midframe();
    logic [6:0] d_old [4];
    logic [6:0] d_new [4];
    logic [6:0] ws;
    logic [3:0] e;
    d_old = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100};
    d_new = '{7'b0100100, 7'b1111001, 7'b0110000, 7'b0100100};
    while (n < 80) step();
    repeat (80) begin
      step();
      if (n == 95) minutes = 6'd12;
      e = exp_anode(n, 4'b0000);
      total++;
      if (anode !== e) $display("FAIL midframe_anode n=%0d got %b want %b", n, anode, e);
      else passed++;
      if (e != 4'hF) begin
        ws = (n <= 120) ? d_old[pos(n)] : d_new[pos(n)];
        total++;
        if (seg !== ws) $display("FAIL midframe_seg n=%0d got %b want %b", n, seg, ws);
        else passed++;
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] digs [4];
    logic [3:0] e;
    logic [3:0] mask;
    digs = '{7'b0100100, 7'b1111001, 7'b0110000, 7'b0100100};
    while (n < 160) step();
    adjust_sel = 2'b01;
    repeat (160) begin
      step();
      if (n == 240) adjust_sel = 2'b10;
      if (n <= 240) mask = ph(n) ? 4'b1100 : 4'b0000;
      else          mask = ph(n) ? 4'b0011 : 4'b0000;
      e = exp_anode(n, mask);
      total++;
      if (anode !== e) $display("FAIL blink_anode n=%0d sel=%b got %b want %b", n, adjust_sel, anode, e);
      else passed++;
      if (e != 4'hF) begin
        total++;
        if (seg !== digs[pos(n)]) $display("FAIL blink_seg n=%0d got %b want %b", n, seg, digs[pos(n)]);
        else passed++;
      end
    end
    adjust_sel = 2'b00;
  endtask

  task automatic test_range();
    logic [6:0] d_bad [4];
    logic [6:0] d_lb [4];
    logic [6:0] d_ref [4];
    logic [3:0] e, e_lb;
    d_bad = '{7'b0010000, 7'b0010010, 7'b0111111, 7'b0111111};
    d_lb  = '{7'b0010000, 7'b0010010, 7'b1111000, 7'b1000000};
    d_ref = '{7'b0010000, 7'b0010010, 7'b1111000, 7'b1000000};
    hours = 5'd30;
    minutes = 6'd59;
    while (n < 360) step();
    repeat (40) begin
      step();
      e = exp_anode(n, 4'b0000);
      total++;
      if (anode !== e || anode_lb !== e)
        $display("FAIL range_anode n=%0d got %b/%b want %b", n, anode, anode_lb, e);
      else passed++;
      if (e != 4'hF) begin
        total++;
        if (seg !== d_bad[pos(n)] || seg_lb !== d_bad[pos(n)])
          $display("FAIL range_seg n=%0d got %b/%b want %b", n, seg, seg_lb, d_bad[pos(n)]);
        else passed++;
      end
    end
    hours = 5'd7;
    while (n < 440) step();
    repeat (40) begin
      step();
      e    = exp_anode(n, 4'b0000);
      e_lb = exp_anode(n, 4'b1000);
      total++;
      if (anode_lb !== e_lb) $display("FAIL lead_blank_anode n=%0d got %b want %b", n, anode_lb, e_lb);
      else passed++;
      total++;
      if (anode !== e) $display("FAIL no_lead_blank_anode n=%0d got %b want %b", n, anode, e);
      else passed++;
      if (e_lb != 4'hF) begin
        total++;
        if (seg_lb !== d_lb[pos(n)]) $display("FAIL lead_blank_seg n=%0d got %b want %b", n, seg_lb, d_lb[pos(n)]);
        else passed++;
      end
      if (e != 4'hF) begin
        total++;
        if (seg !== d_ref[pos(n)]) $display("FAIL no_lead_blank_seg n=%0d got %b want %b", n, seg, d_ref[pos(n)]);
        else passed++;
      end
    end
  endtask

  task automatic test_colon_and_reset();
    logic ed;
    while (n < 480) step();
    colon_on = 1'b1;
    repeat (24) begin
      step();
      ed = !(!in_guard(n) && pos(n) == 2);
      total++;
      if (dp !== ed) $display("FAIL colon_dp n=%0d anode=%b got %b want %b", n, anode, dp, ed);
      else passed++;
    end
    reset = 1'b0;
    step();
    total++;
    if ({anode, seg, dp} !== {4'hF, 7'h7F, 1'b1})
      $display("FAIL midframe_reset got anode=%b seg=%b dp=%b want 1111 1111111 1", anode, seg, dp);
    else passed++;
    total++;
    if ({anode_lb, seg_lb, dp_lb} !== {4'hF, 7'h7F, 1'b1})
      $display("FAIL midframe_reset_lb got anode=%b seg=%b dp=%b want 1111 1111111 1", anode_lb, seg_lb, dp_lb);
    else passed++;
    step();
    reset = 1'b1;
    n = 0;
    step();
    total++;
    if ({anode, seg, dp} !== {4'b1110, 7'b1000000, 1'b1})
      $display("FAIL post_reset_digit0 got anode=%b seg=%b dp=%b want 1110 1000000 1", anode, seg, dp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_midframe();
    test_blink();
    test_range();
    test_colon_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
